// File: rtl/inj_trig_sequencer.sv
// Charge-injection scan sequencer: repeats INJ/TRIG pulse pairs with a programmed period.
// Outputs are registered from next-state (INJ rises 2 edges after START); near-full FIFO holds the block in CHECK between repetitions.
module inj_trig_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [REP_WIDTH-1:0] CONF_REPEAT,
  input  logic [CNT_WIDTH-1:0] CONF_INJ_WIDTH,
  input  logic [CNT_WIDTH-1:0] CONF_TRIG_DELAY,
  input  logic [CNT_WIDTH-1:0] CONF_TRIG_WIDTH,
  input  logic [CNT_WIDTH-1:0] CONF_PERIOD,
  input  logic                 CONF_EN_TRIG,
  input  logic                 FIFO_NEAR_FULL,
  output logic                 INJ,
  output logic                 TRIG,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 STALL,
  output logic [REP_WIDTH-1:0] INJ_COUNT
);

  localparam int TW = CNT_WIDTH + 1;
  localparam logic [TW-1:0]        T_ONE = TW'(1);
  localparam logic [REP_WIDTH-1:0] C_ONE = REP_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CHECK, RUN} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        t, t_nxt;
  logic [TW-1:0]        pe, pe_calc, trig_end_cfg, trig_end_q;
  logic [REP_WIDTH-1:0] rep_q, count_nxt;
  logic [CNT_WIDTH-1:0] inj_w_q, trig_d_q, trig_w_q;
  logic                 en_trig_q;
  logic                 done_nxt, inj_nxt, trig_nxt, stall_nxt;
  logic                 accept, last_cyc;

  assign accept       = (state == IDLE) && START && !ABORT;
  assign last_cyc     = (state == RUN) && (t == pe - T_ONE);
  assign trig_end_cfg = {1'b0, CONF_TRIG_DELAY} + {1'b0, CONF_TRIG_WIDTH};
  assign trig_end_q   = {1'b0, trig_d_q} + {1'b0, trig_w_q};
  assign BUSY         = (state != IDLE);

  // Period is stretched so the INJ pulse and the whole TRIG window always fit.
  always_comb begin
    pe_calc = {1'b0, CONF_PERIOD};
    if ({1'b0, CONF_INJ_WIDTH} > pe_calc) pe_calc = {1'b0, CONF_INJ_WIDTH};
    if (CONF_EN_TRIG && (trig_end_cfg > pe_calc)) pe_calc = trig_end_cfg;
    if (pe_calc == '0) pe_calc = T_ONE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      t         <= '0;
      INJ_COUNT <= '0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      INJ_COUNT <= count_nxt;
      DONE      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    count_nxt = INJ_COUNT;
    done_nxt  = DONE;
    if (ABORT) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state_nxt = CHECK;
            count_nxt = '0;
            done_nxt  = 1'b0;
          end
        end
        CHECK: begin
          if (!FIFO_NEAR_FULL) begin
            state_nxt = RUN;
            t_nxt     = '0;
          end
        end
        RUN: begin
          if (last_cyc) begin
            count_nxt = INJ_COUNT + C_ONE;
            if ((rep_q != '0) && (count_nxt == rep_q)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = CHECK;
            end
          end else begin
            t_nxt = t + T_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    inj_nxt   = (state_nxt == RUN) && (t_nxt < {1'b0, inj_w_q});
    trig_nxt  = (state_nxt == RUN) && en_trig_q &&
                (t_nxt >= {1'b0, trig_d_q}) && (t_nxt < trig_end_q);
    stall_nxt = (state == CHECK) && (state_nxt == CHECK);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      INJ       <= 1'b0;
      TRIG      <= 1'b0;
      STALL     <= 1'b0;
      pe        <= T_ONE;
      rep_q     <= '0;
      inj_w_q   <= '0;
      trig_d_q  <= '0;
      trig_w_q  <= '0;
      en_trig_q <= 1'b0;
    end else begin
      INJ   <= inj_nxt;
      TRIG  <= trig_nxt;
      STALL <= stall_nxt;
      if (accept) begin
        pe        <= pe_calc;
        rep_q     <= CONF_REPEAT;
        inj_w_q   <= CONF_INJ_WIDTH;
        trig_d_q  <= CONF_TRIG_DELAY;
        trig_w_q  <= CONF_TRIG_WIDTH;
        en_trig_q <= CONF_EN_TRIG;
      end
    end
  end

endmodule

// File: tb/tb_inj_trig_sequencer.sv
// Scoreboard bench: a cycle-indexed reference model queues every expected output change;
// a negedge monitor pops and compares whenever the DUT output vector changes.
module tb_inj_trig_sequencer;
  localparam int CW = 8;
  localparam int RW = 4;

  logic          CLK = 1'b0;
  logic          RST_N, START, ABORT, CONF_EN_TRIG, FIFO_NEAR_FULL;
  logic [RW-1:0] CONF_REPEAT;
  logic [CW-1:0] CONF_INJ_WIDTH, CONF_TRIG_DELAY, CONF_TRIG_WIDTH, CONF_PERIOD;
  logic          INJ, TRIG, BUSY, DONE, STALL;
  logic [RW-1:0] INJ_COUNT;

  inj_trig_sequencer #(.CNT_WIDTH(CW), .REP_WIDTH(RW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .CONF_REPEAT(CONF_REPEAT), .CONF_INJ_WIDTH(CONF_INJ_WIDTH),
    .CONF_TRIG_DELAY(CONF_TRIG_DELAY), .CONF_TRIG_WIDTH(CONF_TRIG_WIDTH),
    .CONF_PERIOD(CONF_PERIOD), .CONF_EN_TRIG(CONF_EN_TRIG),
    .FIFO_NEAR_FULL(FIFO_NEAR_FULL), .INJ(INJ), .TRIG(TRIG), .BUSY(BUSY),
    .DONE(DONE), .STALL(STALL), .INJ_COUNT(INJ_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {int cyc; logic [8:0] v;} ev_t;
  ev_t  exp_q[$];
  int   n_checks = 0, n_pass = 0, cyc = 0;
  bit   mon_en = 0;

  // Reference model: idle / waiting-for-FIFO / running, with the running
  // repetition described only by its start edge and the effective period.
  int m_mode = 0, m_run_start = 0, m_pe = 1, m_count = 0;
  int m_rep = 0, m_iw = 0, m_d = 0, m_tw = 0;
  bit m_en = 0, m_done = 0, m_stall = 0;
  logic [8:0] exp_prev = '0;

  always @(posedge CLK) begin
    int   off;
    bit   e_inj, e_trig;
    logic [8:0] ev;
    cyc++;
    if (!RST_N) begin
      m_mode = 0; m_count = 0; m_done = 0; m_stall = 0;
    end else if (ABORT) begin
      m_mode = 0; m_stall = 0;
    end else if (m_mode == 0) begin
      if (START) begin
        m_rep = int'(CONF_REPEAT); m_iw = int'(CONF_INJ_WIDTH);
        m_d = int'(CONF_TRIG_DELAY); m_tw = int'(CONF_TRIG_WIDTH); m_en = CONF_EN_TRIG;
        m_pe = int'(CONF_PERIOD);
        if (m_iw > m_pe) m_pe = m_iw;
        if (m_en && (m_d + m_tw > m_pe)) m_pe = m_d + m_tw;
        if (m_pe < 1) m_pe = 1;
        m_count = 0; m_done = 0; m_stall = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (FIFO_NEAR_FULL) m_stall = 1;
      else begin m_stall = 0; m_mode = 2; m_run_start = cyc; end
    end else if (cyc - m_run_start == m_pe) begin
      m_count = (m_count + 1) % (1 << RW);
      if (m_rep != 0 && m_count == m_rep) begin m_mode = 0; m_done = 1; end
      else m_mode = 1;
    end
    off    = cyc - m_run_start;
    e_inj  = (m_mode == 2) && (off < m_iw);
    e_trig = (m_mode == 2) && m_en && (off >= m_d) && (off < m_d + m_tw);
    ev = {e_inj, e_trig, (m_mode != 0), m_done, m_stall, RW'(m_count)};
    if (ev != exp_prev) exp_q.push_back('{cyc, ev});
    exp_prev = ev;
  end

  logic [8:0] dut_prev = '0;
  always @(negedge CLK) begin
    logic [8:0] dv;
    ev_t e;
    dv = {INJ, TRIG, BUSY, DONE, STALL, INJ_COUNT};
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        $display("FAIL missed_change cyc=%0d: dut vector %b, required %b at cyc %0d", cyc, dv, e.v, e.cyc);
      end
      if (dv != dut_prev) begin
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL unexpected_change cyc=%0d: dut vector %b, nothing expected", cyc, dv);
        else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v != dv)
            $display("FAIL out_change cyc=%0d: dut {inj,trig,busy,done,stall,cnt}=%b, required %b at cyc %0d",
                     cyc, dv, e.v, e.cyc);
          else n_pass++;
        end
      end
    end
    dut_prev = dv;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) $display("FAIL %s: got %0d, required %0d", name, act, req);
    else n_pass++;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic set_conf(input int rep, input int iw, input int d, input int tw,
                          input int p, input bit en);
    CONF_REPEAT = RW'(rep); CONF_INJ_WIDTH = CW'(iw); CONF_TRIG_DELAY = CW'(d);
    CONF_TRIG_WIDTH = CW'(tw); CONF_PERIOD = CW'(p); CONF_EN_TRIG = en;
  endtask

  task automatic pulse_start();
    START = 1'b1; tick(); START = 1'b0;
  endtask

  task automatic pulse_abort();
    ABORT = 1'b1; tick(); ABORT = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (BUSY && n < max_cyc) begin tick(); n++; end
    if (BUSY) begin
      n_checks++;
      $display("FAIL %s_timeout: BUSY still 1 after %0d cycles, required 0", name, max_cyc);
      pulse_abort();
    end
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; ABORT = 1'b0; FIFO_NEAR_FULL = 1'b0;
    set_conf(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_inj", INJ, 0);   chk("rst_trig", TRIG, 0); chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0); chk("rst_stall", STALL, 0); chk("rst_count", INJ_COUNT, 0);
    tick(); RST_N = 1'b1; mon_en = 1;
    tick(2);

    // Basic sequence
    set_conf(3, 4, 2, 3, 10, 1);
    pulse_start();
    wait_idle("basic", 100);
    chk("basic_done", DONE, 1); chk("basic_count", INJ_COUNT, 3);
    tick(3);

    // Period stretched by the trigger window
    set_conf(2, 5, 6, 4, 2, 1);
    pulse_start();
    wait_idle("stretch", 100);
    chk("stretch_count", INJ_COUNT, 2);
    tick(2);

    // FIFO near-full for 20 cycles at the second CHECK
    set_conf(3, 4, 2, 3, 10, 1);
    pulse_start();
    tick(11);
    FIFO_NEAR_FULL = 1'b1;
    tick(10);
    chk("stall_level", STALL, 1); chk("stall_inj", INJ, 0); chk("stall_count", INJ_COUNT, 1);
    tick(10);
    FIFO_NEAR_FULL = 1'b0;
    wait_idle("stall", 150);
    chk("stall_final_count", INJ_COUNT, 3); chk("stall_final_done", DONE, 1);
    tick(2);

    // Abort at t=2 of the second repetition, then restart
    pulse_start();
    tick(14);
    chk("pre_abort_inj", INJ, 1);
    pulse_abort();
    chk("abort_inj", INJ, 0);   chk("abort_trig", TRIG, 0); chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0); chk("abort_count", INJ_COUNT, 1);
    pulse_start();
    wait_idle("restart", 100);
    chk("restart_done", DONE, 1); chk("restart_count", INJ_COUNT, 3);
    tick(2);

    // Endless mode: 20 repetitions wrap a 4-bit counter to 4
    set_conf(0, 1, 0, 0, 3, 0);
    pulse_start();
    tick(80);
    chk("endless_busy", BUSY, 1); chk("endless_done", DONE, 0);
    pulse_abort();
    chk("endless_count", INJ_COUNT, 4); chk("endless_stopped", BUSY, 0);
    tick(2);

    // START while busy with changed CONF is ignored
    set_conf(3, 4, 2, 3, 10, 1);
    pulse_start();
    tick(5);
    set_conf(1, 1, 0, 0, 50, 0);
    pulse_start();
    wait_idle("ignored_start", 100);
    chk("ignored_start_count", INJ_COUNT, 3);
    tick(2);

    // START and ABORT together in IDLE
    START = 1'b1; ABORT = 1'b1; tick(); START = 1'b0; ABORT = 1'b0;
    tick();
    chk("start_abort_busy", BUSY, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int len;
      set_conf($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(0, 4), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      pulse_start();
      len = $urandom_range(10, 80);
      for (int c = 0; c < len; c++) begin
        FIFO_NEAR_FULL = ($urandom_range(0, 4) == 0);
        ABORT = ($urandom_range(0, 49) == 0);
        START = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0)
          set_conf($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 6),
                   $urandom_range(0, 4), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
        tick();
      end
      START = 1'b0; ABORT = 1'b0; FIFO_NEAR_FULL = 1'b0;
      for (int w = 0; w < 60 && BUSY; w++) tick();
      pulse_abort();
      chk("rand_idle", BUSY, 0);
      tick(2);
    end

    tick(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    mon_en = 0;

    // Reset asserted mid-pulse drops outputs without a clock edge
    set_conf(1, 20, 0, 5, 30, 1);
    pulse_start();
    tick(3);
    chk("pre_rst_inj", INJ, 1); chk("pre_rst_trig", TRIG, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_inj", INJ, 0); chk("async_rst_trig", TRIG, 0);
    chk("async_rst_busy", BUSY, 0); chk("async_rst_count", INJ_COUNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
